// File: rtl/io_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : io_command_scheduler
// Description : Timed command scheduler between the UART command decoder and
//               the IO module. Decoded commands {instr, reg, time} are queued
//               in a small FIFO. The head command is issued once the free-
//               running timer has reached its time and the IO module is idle.
//               The IO busy handshake is then followed to completion.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               control_value         - command word {instr, reg, time}
//               valid_control_value   - enqueue request
//               cmd_ready             - FIFO not full (combinational)
//               time_clear            - zero the timer
//               busy_io_module        - IO module executing
//               instrucction/register/clock_time - last issued command fields
//               valid_instrucction    - one-cycle issue pulse
//               cmd_done              - one-cycle completion pulse
//               queue_count           - entries held in the FIFO
//               now                   - current timer value
//               overflow_err          - sticky, push attempted while full
//               ack_timeout_err       - sticky, IO never went busy after issue
// Revision    : 1.0 - initial release
// ============================================================================
module io_command_scheduler #(
   parameter int INPUT_DATA_SIZE    = 40,
   parameter int WORD_SIZE          = 32,
   parameter int INSTRUCTION_SIZE   = 3,
   parameter int SIZE_WORD_REGISTER = 5,
   parameter int DEPTH              = 4,
   parameter int ACK_TIMEOUT        = 15
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [INPUT_DATA_SIZE-1:0]    control_value,
   input  logic                          valid_control_value,
   output logic                          cmd_ready,
   input  logic                          time_clear,
   input  logic                          busy_io_module,
   output logic [INSTRUCTION_SIZE-1:0]   instrucction,
   output logic [SIZE_WORD_REGISTER-1:0] register,
   output logic [WORD_SIZE-1:0]          clock_time,
   output logic                          valid_instrucction,
   output logic                          cmd_done,
   output logic [$clog2(DEPTH):0]        queue_count,
   output logic [WORD_SIZE-1:0]          now,
   output logic                          overflow_err,
   output logic                          ack_timeout_err
);

   localparam int                AW         = $clog2(DEPTH);
   localparam int                CW         = AW + 1;
   localparam logic [CW-1:0]     FULL_COUNT = CW'(DEPTH);
   localparam logic [7:0]        ACK_LAST   = 8'(ACK_TIMEOUT - 1);
   localparam logic [WORD_SIZE-1:0] ONE     = WORD_SIZE'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_TIME = 3'd1,
      S_ISSUE     = 3'd2,
      S_WAIT_ACK  = 3'd3,
      S_WAIT_DONE = 3'd4
   } state_t;

   state_t                          state_q, state_d;
   logic [INPUT_DATA_SIZE-1:0]      mem_q [DEPTH];
   logic [AW-1:0]                   rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]                   count_q;
   logic [WORD_SIZE-1:0]            now_q;
   logic [7:0]                      ack_cnt_q, ack_cnt_d;
   logic                            valid_q, valid_d;
   logic                            done_q, done_d;
   logic                            ovf_q;
   logic                            ack_err_q, ack_err_d;
   logic [INSTRUCTION_SIZE-1:0]     instr_q, instr_d;
   logic [SIZE_WORD_REGISTER-1:0]   reg_q, reg_d;
   logic [WORD_SIZE-1:0]            time_q, time_d;

   logic [INPUT_DATA_SIZE-1:0]      head_w;
   logic [WORD_SIZE-1:0]            diff_w;
   logic                            due_w;
   logic                            push_w;
   logic                            pop_w;

   // Ready depends only on the registered count, so a pop in the same cycle
   // never lets a push into a full FIFO.
   assign cmd_ready = (count_q != FULL_COUNT);
   assign push_w    = valid_control_value & cmd_ready;
   assign pop_w     = (state_q == S_ISSUE);

   assign head_w = mem_q[rd_ptr_q];
   // Wrap-safe due test: the head is due once (now - T) is non-negative when
   // read as a signed 32-bit distance.
   assign diff_w = now_q - head_w[WORD_SIZE-1:0];
   assign due_w  = ~diff_w[WORD_SIZE-1];

   // FIFO, timer and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         now_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         now_q <= time_clear ? '0 : now_q + ONE;
         if (push_w) begin
            mem_q[wr_ptr_q] <= control_value;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_w) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push_w && !pop_w) begin
            count_q <= count_q + CW'(1);
         end else if (!push_w && pop_w) begin
            count_q <= count_q - CW'(1);
         end
         if (valid_control_value && !cmd_ready) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ack_cnt_q <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         instr_q   <= '0;
         reg_q     <= '0;
         time_q    <= '0;
      end else begin
         state_q   <= state_d;
         ack_cnt_q <= ack_cnt_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         instr_q   <= instr_d;
         reg_q     <= reg_d;
         time_q    <= time_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ack_cnt_d = ack_cnt_q;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      ack_err_d = ack_err_q;
      instr_d   = instr_q;
      reg_d     = reg_q;
      time_d    = time_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d = S_WAIT_TIME;
            end
         end
         S_WAIT_TIME: begin
            if (due_w && !busy_io_module) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            valid_d   = 1'b1;
            instr_d   = head_w[INPUT_DATA_SIZE-1 -: INSTRUCTION_SIZE];
            reg_d     = head_w[WORD_SIZE +: SIZE_WORD_REGISTER];
            time_d    = head_w[WORD_SIZE-1:0];
            ack_cnt_d = '0;
            state_d   = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (busy_io_module) begin
               state_d = S_WAIT_DONE;
            end else if (ack_cnt_q == ACK_LAST) begin
               ack_err_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               ack_cnt_d = ack_cnt_q + 8'd1;
            end
         end
         S_WAIT_DONE: begin
            if (!busy_io_module) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign instrucction       = instr_q;
   assign register           = reg_q;
   assign clock_time         = time_q;
   assign valid_instrucction = valid_q;
   assign cmd_done           = done_q;
   assign queue_count        = count_q;
   assign now                = now_q;
   assign overflow_err       = ovf_q;
   assign ack_timeout_err    = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_io_command_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_command_scheduler
// Description : Self-checking bench for io_command_scheduler. A queue-based
//               reference model tracks accepted commands, the timer and the
//               IO handshake; every cycle the DUT outputs are compared to it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_command_scheduler;

   localparam int DEPTH       = 4;
   localparam int ACK_TIMEOUT = 15;

   typedef struct packed {
      logic [2:0]  ins;
      logic [4:0]  rg;
      logic [31:0] t;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [39:0] ctrl;
   logic        vin;
   logic        cmd_ready;
   logic        tclr;
   logic        busy;
   logic [2:0]  instrucction;
   logic [4:0]  register;
   logic [31:0] clock_time;
   logic        valid_instrucction;
   logic        cmd_done;
   logic [2:0]  queue_count;
   logic [31:0] now;
   logic        overflow_err;
   logic        ack_timeout_err;

   always #5 clk = ~clk;

   io_command_scheduler #(
      .DEPTH       (DEPTH),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .control_value       (ctrl),
      .valid_control_value (vin),
      .cmd_ready           (cmd_ready),
      .time_clear          (tclr),
      .busy_io_module      (busy),
      .instrucction        (instrucction),
      .register            (register),
      .clock_time          (clock_time),
      .valid_instrucction  (valid_instrucction),
      .cmd_done            (cmd_done),
      .queue_count         (queue_count),
      .now                 (now),
      .overflow_err        (overflow_err),
      .ack_timeout_err     (ack_timeout_err)
   );

   int          n_tests = 0;
   int          n_fail  = 0;

   // Reference model state
   cmd_t        m_q[$];
   logic [31:0] m_now, h1, h2;
   logic        m_ovf, m_ackerr, in_ack, in_done;
   int          ack_cnt;
   logic [2:0]  m_ins;
   logic [4:0]  m_rg;
   logic [31:0] m_t;
   int          pulses, dones;
   logic        last_pulse;

   // Automatic IO responder
   logic        io_auto, rsp_active;
   int          rsp_delay, rsp_len;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      int          pre_size;
      logic        exp_done;
      cmd_t        c;
      logic [31:0] diff;
      @(posedge clk);
      pre_size = m_q.size();
      exp_done = 1'b0;
      h2 = h1;
      h1 = m_now;
      if (!rst_n) begin
         m_q.delete();
         m_now = '0; m_ovf = 1'b0; m_ackerr = 1'b0;
         in_ack = 1'b0; in_done = 1'b0; ack_cnt = 0;
         m_ins = '0; m_rg = '0; m_t = '0;
         pre_size = 0;
         rsp_active = 1'b0;
      end else begin
         m_now = tclr ? 32'd0 : m_now + 32'd1;
         if (in_done && !busy) begin
            exp_done = 1'b1;
            in_done  = 1'b0;
         end else if (in_ack) begin
            if (busy) begin
               in_ack  = 1'b0;
               in_done = 1'b1;
            end else begin
               ack_cnt++;
               if (ack_cnt == ACK_TIMEOUT) begin
                  m_ackerr = 1'b1;
                  in_ack   = 1'b0;
               end
            end
         end
         if (vin) begin
            if (pre_size < DEPTH) m_q.push_back(cmd_t'(ctrl));
            else m_ovf = 1'b1;
         end
      end
      #1;
      if (valid_instrucction === 1'b1) begin
         pulses++;
         check("issue_from_nonempty", pre_size != 0, 1'b1);
         if (pre_size != 0 && m_q.size() != 0) begin
            c = m_q.pop_front();
            m_ins = c.ins; m_rg = c.rg; m_t = c.t;
            diff = h2 - c.t;
            check("issue_due", diff[31], 1'b0);
         end
         in_ack  = 1'b1;
         ack_cnt = 0;
         if (io_auto) begin
            rsp_active = 1'b1;
            rsp_delay  = $urandom_range(0, 3);
            rsp_len    = $urandom_range(1, 4);
         end
      end
      check("valid_single_cycle", valid_instrucction & last_pulse, 1'b0);
      last_pulse = valid_instrucction;
      check("cmd_done", cmd_done, exp_done);
      if (cmd_done === 1'b1) dones++;
      check("now", now, m_now);
      check("queue_count", queue_count, m_q.size());
      check("cmd_ready", cmd_ready, m_q.size() != DEPTH);
      check("overflow_err", overflow_err, m_ovf);
      check("ack_timeout_err", ack_timeout_err, m_ackerr);
      check("instrucction", instrucction, m_ins);
      check("register", register, m_rg);
      check("clock_time", clock_time, m_t);
      if (io_auto && rsp_active) begin
         if (rsp_delay > 0) begin
            rsp_delay--;
            busy = 1'b0;
         end else if (rsp_len > 0) begin
            busy = 1'b1;
            rsp_len--;
         end else begin
            busy       = 1'b0;
            rsp_active = 1'b0;
         end
      end
   endtask

   task automatic push_cmd(input logic [2:0] i, input logic [4:0] r, input logic [31:0] t);
      vin  = 1'b1;
      ctrl = {i, r, t};
      tick();
      vin  = 1'b0;
   endtask

   task automatic wait_pulse(input int bound, output int lat);
      int p0;
      p0  = pulses;
      lat = 0;
      while (pulses == p0 && lat < bound) begin
         tick();
         lat++;
      end
      check("pulse_within_bound", pulses != p0, 1'b1);
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((m_q.size() != 0 || in_ack || in_done || rsp_active) && n < bound) begin
         tick();
         n++;
      end
      check("drain_within_bound", n < bound, 1'b1);
      repeat (2) tick();
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, p0, d0;
      rst_n = 1'b0; vin = 1'b0; ctrl = '0; tclr = 1'b0; busy = 1'b0;
      io_auto = 1'b0; rsp_active = 1'b0; rsp_delay = 0; rsp_len = 0;
      m_now = '0; h1 = '0; h2 = '0; m_ovf = 1'b0; m_ackerr = 1'b0;
      in_ack = 1'b0; in_done = 1'b0; ack_cnt = 0;
      m_ins = '0; m_rg = '0; m_t = '0; pulses = 0; dones = 0; last_pulse = 1'b0;

      // Reset state
      do_reset(2);
      check("reset_cmd_ready", cmd_ready, 1'b1);

      // Basic issue, latency and completion
      push_cmd(3'b001, 5'd5, 32'd0);
      wait_pulse(10, lat);
      check("issue_latency", lat, 3);
      check("issue_instr", instrucction, 3'b001);
      check("issue_reg", register, 5'd5);
      d0 = dones;
      busy = 1'b1;
      repeat (4) tick();
      busy = 1'b0;
      tick();
      check("done_seen", dones - d0, 1);
      tick();
      check("queue_empty_after_done", queue_count, 3'd0);

      // Timed issue after time_clear
      io_auto = 1'b1;
      tclr = 1'b1;
      tick();
      tclr = 1'b0;
      push_cmd(3'd2, 5'd9, 32'd100);
      wait_pulse(200, lat);
      check("t100_window", (m_now >= 32'd100) && (m_now <= 32'd103), 1'b1);
      drain(50);

      // Far-future head must hold; a time just before the wrap is already due
      p0 = pulses;
      push_cmd(3'd3, 5'd1, m_now + 32'h7000_0000);
      repeat (40) tick();
      check("far_future_held", pulses - p0, 0);
      do_reset(2);
      push_cmd(3'd4, 5'd2, 32'hFFFF_FFF0);
      wait_pulse(10, lat);
      check("wrapped_past_latency", lat, 3);
      drain(50);

      // Overflow with IO busy
      io_auto = 1'b0;
      busy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         push_cmd(3'(k + 1), 5'(k + 10), 32'd0);
      end
      check("full_count", queue_count, 3'd4);
      check("full_not_ready", cmd_ready, 1'b0);
      check("overflow_set", overflow_err, 1'b1);
      p0 = pulses;
      busy = 1'b0;
      io_auto = 1'b1;
      drain(300);
      check("overflow_drained_four", pulses - p0, 4);

      // Ack timeout then recovery
      io_auto = 1'b0;
      busy = 1'b0;
      push_cmd(3'd5, 5'd20, 32'd0);
      wait_pulse(10, lat);
      repeat (16) tick();
      check("ack_timeout_set", ack_timeout_err, 1'b1);
      io_auto = 1'b1;
      push_cmd(3'd6, 5'd21, 32'd0);
      wait_pulse(20, lat);
      drain(50);

      // Reset during WAIT_DONE with two queued
      io_auto = 1'b0;
      busy = 1'b0;
      push_cmd(3'd1, 5'd3, 32'd0);
      push_cmd(3'd2, 5'd4, 32'd0);
      push_cmd(3'd3, 5'd6, 32'd0);
      wait_pulse(10, lat);
      busy = 1'b1;
      repeat (2) tick();
      check("two_queued", queue_count, 3'd2);
      d0 = dones;
      rst_n = 1'b0;
      tick();
      busy = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      check("no_done_after_reset", dones - d0, 0);
      check("reset_queue_empty", queue_count, 3'd0);
      check("reset_valid_low", valid_instrucction, 1'b0);

      // Randomised traffic against the model
      io_auto = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            vin  = 1'b1;
            ctrl = {3'($urandom), 5'($urandom), m_now + 32'($urandom_range(0, 25))};
         end else begin
            vin = 1'b0;
         end
         tick();
      end
      vin = 1'b0;
      drain(800);
      check("random_drained", queue_count, 3'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
